// File: rtl/bridge_rx_generic_pkg.sv
// Shared constants and types for the ASCII-hex bridge receiver and its future
// transmit counterpart.
package bridge_pkg;

    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BAD_CHAR = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_SHORT    = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } parser_state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CHAR_R) || (b == CHAR_W);
    endfunction

endpackage

// File: rtl/bridge_rx_generic_if.sv
// Byte-stream input and decoded bus-transaction output of the bridge receiver.
interface bridge_rx_generic_if #(
    parameter int ADDR_NIBBLES = 4,
    parameter int DATA_NIBBLES = 4
);
    logic [7:0]                  data_i;
    logic                        valid_i;
    logic [4*ADDR_NIBBLES-1:0]   addr_o;
    logic [4*DATA_NIBBLES-1:0]   data_o;
    logic                        rw_o;
    logic                        valid_o;
    logic                        err_o;
    logic [1:0]                  err_code_o;

    modport slave (
        input  data_i, valid_i,
        output addr_o, data_o, rw_o, valid_o, err_o, err_code_o
    );

    modport master (
        output data_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o, err_o, err_code_o
    );
endinterface

// File: rtl/bridge_rx_generic_ascii_hex_decode.sv
// Combinational ASCII hex digit classifier; lowercase acceptance is selectable.
module ascii_hex_decode (
    input  logic [7:0] byte_i,
    input  logic       accept_lc_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    // Classify the byte and map it onto its nibble value
    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if ((byte_i >= 8'h30) && (byte_i <= 8'h39)) begin
            is_hex_o = 1'b1;
            nibble_o = byte_i[3:0];
        end else if ((byte_i >= 8'h41) && (byte_i <= 8'h46)) begin
            is_hex_o = 1'b1;
            nibble_o = byte_i[3:0] + 4'd9;
        end else if (accept_lc_i && (byte_i >= 8'h61) && (byte_i <= 8'h66)) begin
            is_hex_o = 1'b1;
            nibble_o = byte_i[3:0] + 4'd9;
        end else begin
            is_hex_o = 1'b0;
            nibble_o = 4'h0;
        end
    end

endmodule

// File: rtl/bridge_rx_generic.sv
// ASCII-hex frame parser: turns 'R'/'W' frames from a UART byte stream into
// single-cycle bus transactions, with error strobes, timeout and resync.
module bridge_rx_generic
    import bridge_pkg::*;
#(
    parameter int ADDR_NIBBLES     = 4,
    parameter int DATA_NIBBLES     = 4,
    parameter int TIMEOUT_CYCLES   = 100000,
    parameter int ACCEPT_LOWERCASE = 1
) (
    input  logic                clk,
    input  logic                rst,
    bridge_rx_generic_if.slave  bus
);

    localparam int AW = 4 * ADDR_NIBBLES;
    localparam int DW = 4 * DATA_NIBBLES;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0]    S_IDLE    = IDLE;
    localparam logic [1:0]    S_ADDR    = ADDR;
    localparam logic [1:0]    S_DATA    = DATA;
    localparam logic [1:0]    S_TERM    = TERM;
    localparam logic [3:0]    ADDR_LAST = 4'(ADDR_NIBBLES - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_NIBBLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    st_q, st_d;
    logic          rw_q, rw_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_sr_q, addr_sr_d;
    logic [DW-1:0] data_sr_q, data_sr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rwo_q, rwo_d;

    logic          is_hex_s;
    logic [3:0]    nib_s;

    ascii_hex_decode u_dec (
        .byte_i      (bus.data_i),
        .accept_lc_i (1'(ACCEPT_LOWERCASE != 0)),
        .is_hex_o    (is_hex_s),
        .nibble_o    (nib_s)
    );

    // Parser next-state, shift registers, timeout and output strobes
    always_comb begin
        st_d      = st_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        addr_sr_d = addr_sr_q;
        data_sr_d = data_sr_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        code_d    = ERR_NONE;
        addr_d    = '0;
        wdata_d   = '0;
        rwo_d     = 1'b0;

        if ((st_q == S_IDLE) || bus.valid_i) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (bus.valid_i) begin
            if (is_cmd(bus.data_i)) begin
                // A command byte always (re)starts a frame; mid-frame it also flags the lost one
                if (st_q != S_IDLE) begin
                    err_d  = 1'b1;
                    code_d = ERR_BAD_CHAR;
                end else begin
                    err_d  = 1'b0;
                end
                st_d      = S_ADDR;
                rw_d      = (bus.data_i == CHAR_W);
                cnt_d     = 4'd0;
                addr_sr_d = '0;
                data_sr_d = '0;
            end else if (st_q == S_IDLE) begin
                st_d = S_IDLE;
            end else if (is_term(bus.data_i)) begin
                if (st_q == S_TERM) begin
                    valid_d = 1'b1;
                    addr_d  = addr_sr_q;
                    wdata_d = rw_q ? data_sr_q : '0;
                    rwo_d   = rw_q;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_SHORT;
                end
                st_d      = S_IDLE;
                rw_d      = 1'b0;
                cnt_d     = 4'd0;
                addr_sr_d = '0;
                data_sr_d = '0;
            end else if (is_hex_s && (st_q != S_TERM)) begin
                case (st_q)
                    S_ADDR: begin
                        addr_sr_d = (addr_sr_q << 4) | AW'(nib_s);
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d = 4'd0;
                            st_d  = rw_q ? S_DATA : S_TERM;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    S_DATA: begin
                        data_sr_d = (data_sr_q << 4) | DW'(nib_s);
                        if (cnt_q == DATA_LAST) begin
                            cnt_d = 4'd0;
                            st_d  = S_TERM;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    default: begin
                        st_d = S_IDLE;
                    end
                endcase
            end else begin
                err_d     = 1'b1;
                code_d    = ERR_BAD_CHAR;
                st_d      = S_IDLE;
                rw_d      = 1'b0;
                cnt_d     = 4'd0;
                addr_sr_d = '0;
                data_sr_d = '0;
            end
        end else if (TMO_EN && (st_q != S_IDLE) && (tmo_q == TMO_LAST)) begin
            err_d     = 1'b1;
            code_d    = ERR_TIMEOUT;
            st_d      = S_IDLE;
            rw_d      = 1'b0;
            cnt_d     = 4'd0;
            addr_sr_d = '0;
            data_sr_d = '0;
        end else begin
            st_d = st_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= S_IDLE;
            rw_q      <= 1'b0;
            cnt_q     <= 4'd0;
            addr_sr_q <= '0;
            data_sr_q <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rwo_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            rw_q      <= rw_d;
            cnt_q     <= cnt_d;
            addr_sr_q <= addr_sr_d;
            data_sr_q <= data_sr_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rwo_q     <= rwo_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;
    assign bus.addr_o     = addr_q;
    assign bus.data_o     = wdata_q;
    assign bus.rw_o       = rwo_q;

endmodule

// File: tb/tb_bridge_rx_generic.sv
// Scoreboard bench: three parser configurations driven with directed frames,
// expected strobes queued with their due cycle and checked by per-DUT monitors.
module tb_bridge_rx_generic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [31:0] data;
        bit          rw;
        int          due;
    } exp_t;

    exp_t q[3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bridge_rx_generic_if #(.ADDR_NIBBLES(4), .DATA_NIBBLES(4)) if_a ();
    bridge_rx_generic_if #(.ADDR_NIBBLES(2), .DATA_NIBBLES(4)) if_b ();
    bridge_rx_generic_if #(.ADDR_NIBBLES(4), .DATA_NIBBLES(4)) if_c ();

    bridge_rx_generic #(.ADDR_NIBBLES(4), .DATA_NIBBLES(4), .TIMEOUT_CYCLES(50),
                        .ACCEPT_LOWERCASE(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    bridge_rx_generic #(.ADDR_NIBBLES(2), .DATA_NIBBLES(4), .TIMEOUT_CYCLES(0),
                        .ACCEPT_LOWERCASE(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    bridge_rx_generic #(.ADDR_NIBBLES(4), .DATA_NIBBLES(4), .TIMEOUT_CYCLES(0),
                        .ACCEPT_LOWERCASE(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int idx, input logic vld, input logic err, input logic [1:0] code,
                       input logic [31:0] addr, input logic [31:0] data, input logic rw);
        exp_t e;
        while (q[idx].size() > 0 && q[idx][0].due < cyc) begin
            e = q[idx].pop_front();
            checks++;
            errors++;
            $display("FAIL dut%0d missed strobe: got none expected err=%0d due cycle %0d",
                     idx, e.is_err, e.due);
        end
        if (vld && err) begin
            checks++;
            errors++;
            $display("FAIL dut%0d exclusive: got valid_o=1 err_o=1 expected at most one", idx);
        end
        if (vld || err) begin
            if (q[idx].size() == 0 || q[idx][0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected strobe: got valid=%0d err=%0d expected none at cycle %0d",
                         idx, vld, err, cyc);
            end else begin
                e = q[idx].pop_front();
                chk($sformatf("dut%0d err_o", idx), 32'(err), 32'(e.is_err));
                if (e.is_err) begin
                    chk($sformatf("dut%0d err_code_o", idx), 32'(code), 32'(e.code));
                end else begin
                    chk($sformatf("dut%0d addr_o", idx), addr, e.addr);
                    chk($sformatf("dut%0d data_o", idx), data, e.data);
                    chk($sformatf("dut%0d rw_o", idx), 32'(rw), 32'(e.rw));
                end
            end
        end else begin
            chk($sformatf("dut%0d idle fields", idx), addr | data | 32'(rw), 32'h0);
        end
    endtask

    always @(negedge clk) mon(0, if_a.valid_o, if_a.err_o, if_a.err_code_o,
                              32'(if_a.addr_o), 32'(if_a.data_o), if_a.rw_o);
    always @(negedge clk) mon(1, if_b.valid_o, if_b.err_o, if_b.err_code_o,
                              32'(if_b.addr_o), 32'(if_b.data_o), if_b.rw_o);
    always @(negedge clk) mon(2, if_c.valid_o, if_c.err_o, if_c.err_code_o,
                              32'(if_c.addr_o), 32'(if_c.data_o), if_c.rw_o);

    // Queue an expected strobe for the byte at position pos of the next string sent
    task automatic exp_at(input int idx, input bit is_err, input logic [1:0] code,
                          input logic [31:0] addr, input logic [31:0] data, input bit rw,
                          input int pos);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.addr   = addr;
        e.data   = data;
        e.rw     = rw;
        e.due    = cyc + 1 + pos;
        q[idx].push_back(e);
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        case (idx)
            0: begin if_a.data_i = b; if_a.valid_i = 1'b1; end
            1: begin if_b.data_i = b; if_b.valid_i = 1'b1; end
            default: begin if_c.data_i = b; if_c.valid_i = 1'b1; end
        endcase
        @(negedge clk);
        if_a.valid_i = 1'b0;
        if_b.valid_i = 1'b0;
        if_c.valid_i = 1'b0;
    endtask

    task automatic send_str(input int idx, input string s);
        for (int i = 0; i < s.len(); i++) send(idx, s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        if_a.data_i = 8'h00; if_a.valid_i = 1'b0;
        if_b.data_i = 8'h00; if_b.valid_i = 1'b0;
        if_c.data_i = 8'h00; if_c.valid_i = 1'b0;
        #1;
        chk("reset valid_o", 32'({if_a.valid_o, if_b.valid_o, if_c.valid_o}), 32'h0);
        chk("reset err_o", 32'({if_a.err_o, if_b.err_o, if_c.err_o}), 32'h0);
        chk("reset err_code_o", 32'({if_a.err_code_o, if_b.err_code_o, if_c.err_code_o}), 32'h0);
        chk("reset addr_o", 32'(if_a.addr_o), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        exp_at(0, 1'b0, 2'b00, 32'h12AB, 32'h5A5F, 1'b1, 9);
        send_str(0, "W12AB5A5F\r");
        idle(2);
        exp_at(0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 3);
        send_str(0, "R12G4\r");
        idle(2);
        exp_at(0, 1'b1, 2'b11, 32'h0, 32'h0, 1'b0, 3);
        send_str(0, "W12\r");
        exp_at(0, 1'b0, 2'b00, 32'h0001, 32'h0, 1'b0, 5);
        send_str(0, "R0001\r");
        idle(2);
        exp_at(0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 2);
        exp_at(0, 1'b0, 2'b00, 32'h0001, 32'h0002, 1'b1, 11);
        send_str(0, "R1W00010002\r");
        idle(2);
        exp_at(0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 5);
        send_str(0, "R1234A\r");
        idle(2);

        // Timeout fires 50 cycles after the last byte; a byte in the expiry cycle wins
        exp_at(0, 1'b1, 2'b10, 32'h0, 32'h0, 1'b0, 2 + 50);
        send_str(0, "R12");
        idle(60);
        send_str(0, "R12");
        idle(49);
        exp_at(0, 1'b0, 2'b00, 32'h1234, 32'h0, 1'b0, 2);
        send_str(0, "34\r");
        idle(60);

        send_str(0, "W12A");
        rst = 1'b1;
        #1;
        chk("midframe rst valid_o", 32'(if_a.valid_o), 32'h0);
        chk("midframe rst err_o", 32'(if_a.err_o), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(1);
        exp_at(0, 1'b0, 2'b00, 32'hBEEF, 32'h0001, 1'b1, 9);
        send_str(0, "WBEEF0001\r");
        idle(2);

        exp_at(1, 1'b0, 2'b00, 32'h3F, 32'h0, 1'b0, 3);
        exp_at(1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, 7);
        send_str(1, "R3f\nR40\r");
        exp_at(1, 1'b0, 2'b00, 32'h7A, 32'h12C4, 1'b1, 8);
        send_str(1, "\nW7a12c4\r\n");
        idle(2);

        exp_at(2, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 1);
        send_str(2, "Ra000\r");
        exp_at(2, 1'b0, 2'b00, 32'hA000, 32'h0, 1'b0, 5);
        send_str(2, "RA000\r");
        idle(4);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d pending expectations", i), 32'(q[i].size()), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
